// File: rtl/i2so_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2so_pkg : shared constants and state type for the I2S output sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package i2so_pkg;

  localparam int unsigned C_DATA_W = 16;
  localparam int unsigned C_DIV_W  = 8;

  localparam logic [7:0] C_UF_SAT = 8'hFF;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_PRIME = 2'd1;
  localparam logic [1:0] C_RUN   = 2'd2;
  localparam logic [1:0] C_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = C_IDLE,
    ST_PRIME = C_PRIME,
    ST_RUN   = C_RUN,
    ST_DRAIN = C_DRAIN
  } state_t;

endpackage
`default_nettype wire

// File: rtl/i2so_sample_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2so_sample_fifo : 2-entry FIFO holding {left, right} sample pairs
// Rev 1.0
// ----------------------------------------------------------------------------
module i2so_sample_fifo
  import i2so_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * C_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2so_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2so_ctrl : I2S output sequencer - SCK divider, sample buffering, stream FSM
// Rev 1.0
// ----------------------------------------------------------------------------
module i2so_ctrl
  import i2so_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W,
  parameter int unsigned DIV_W  = C_DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_mute,
  input  logic              cfg_uf_repeat,
  input  logic              stat_clr,
  input  logic              filt_valid,
  input  logic [DATA_W-1:0] filt_lft,
  input  logic [DATA_W-1:0] filt_rgt,
  output logic              filt_ready,
  output logic              i2so_sck,
  output logic              sck_transition,
  output logic              ser_rts,
  input  logic              ser_rtr,
  output logic [DATA_W-1:0] ser_lft,
  output logic [DATA_W-1:0] ser_rgt,
  output logic              busy,
  output logic [7:0]        stat_uf_cnt,
  output logic              stat_of
);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic                sck_q, sck_d;
  logic                trans_q, trans_d;
  logic                rts_q, rts_d;
  logic [DATA_W-1:0]   last_lft_q, last_lft_d;
  logic [DATA_W-1:0]   last_rgt_q, last_rgt_d;
  logic [7:0]          uf_q, uf_d;
  logic                of_q, of_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [2*DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0]   head_lft;
  logic [DATA_W-1:0]   head_rgt;
  logic                rtr_run;
  logic                div_wrap;

  assign head_lft  = fifo_head[2*DATA_W-1:DATA_W];
  assign head_rgt  = fifo_head[DATA_W-1:0];
  assign rtr_run   = ser_rtr && (state_q == ST_RUN);
  assign fifo_push = filt_valid && !fifo_full;
  assign fifo_pop  = rtr_run && !fifo_empty;
  assign div_wrap  = (cnt_q == div_q);

  i2so_sample_fifo #(
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({filt_lft, filt_rgt}),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    sck_d      = sck_q;
    trans_d    = 1'b0;
    rts_d      = rts_q;
    last_lft_d = last_lft_q;
    last_rgt_d = last_rgt_q;
    uf_d       = uf_q;
    of_d       = of_q;

    case (state_q)
      ST_IDLE: begin
        sck_d = 1'b0;
        cnt_d = '0;
        if (cfg_en) begin
          state_d = ST_PRIME;
          div_d   = cfg_div;
        end
      end
      ST_PRIME: begin
        sck_d = 1'b0;
        cnt_d = '0;
        if (!cfg_en) begin
          state_d = ST_IDLE;
        end else if (!fifo_empty) begin
          state_d = ST_RUN;
          rts_d   = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (div_wrap) begin
          cnt_d   = '0;
          sck_d   = ~sck_q;
          trans_d = ~sck_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ST_RUN) begin
          if (!cfg_en) state_d = ST_DRAIN;
        end else if (ser_rtr) begin
          // Frame boundary reached: park the bit clock low and stop.
          state_d = ST_IDLE;
          cnt_d   = '0;
          sck_d   = 1'b0;
          trans_d = 1'b0;
          rts_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fifo_pop) begin
      last_lft_d = head_lft;
      last_rgt_d = head_rgt;
    end
    if (rtr_run && fifo_empty && (uf_q != C_UF_SAT)) uf_d = uf_q + 8'd1;
    if (filt_valid && fifo_full) of_d = 1'b1;
    if (stat_clr) begin
      uf_d = 8'd0;
      of_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      sck_q      <= 1'b0;
      trans_q    <= 1'b0;
      rts_q      <= 1'b0;
      last_lft_q <= '0;
      last_rgt_q <= '0;
      uf_q       <= 8'd0;
      of_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      sck_q      <= sck_d;
      trans_q    <= trans_d;
      rts_q      <= rts_d;
      last_lft_q <= last_lft_d;
      last_rgt_q <= last_rgt_d;
      uf_q       <= uf_d;
      of_q       <= of_d;
    end
  end

  // The serializer captures on the strobe cycle, so the data path is combinational.
  always_comb begin
    ser_lft = '0;
    ser_rgt = '0;
    if (!cfg_mute) begin
      if (!fifo_empty) begin
        ser_lft = head_lft;
        ser_rgt = head_rgt;
      end else if (cfg_uf_repeat) begin
        ser_lft = last_lft_q;
        ser_rgt = last_rgt_q;
      end
    end
  end

  assign filt_ready     = !fifo_full;
  assign i2so_sck       = sck_q;
  assign sck_transition = trans_q;
  assign ser_rts        = rts_q;
  assign busy           = (state_q != ST_IDLE);
  assign stat_uf_cnt    = uf_q;
  assign stat_of        = of_q;

endmodule
`default_nettype wire
